// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer with a small CSR map (CTRL, INT_EN, W1C STATUS, 8 scratch words),
// a configurable number of wait states and a registered interrupt output.
module apb_slave_regs #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   input  logic                  Tx_done_i,
   input  logic                  Rx_done_i,
   input  logic                  Arb_done_i,
   output logic                  Intr
);

   localparam int unsigned NumScratch = 8;
   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(32'h28);
   localparam logic [2:0] WaitLoad = 3'(WAIT_STATES);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_q, wr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [2:0]            int_en_q, int_en_d;
   logic [2:0]            status_q, status_d;
   logic [DATA_WIDTH-1:0] scratch_q [NumScratch];
   logic [DATA_WIDTH-1:0] scratch_d [NumScratch];
   logic                  intr_q;

   logic                  access;
   logic                  addr_err;
   logic                  wr_en;
   logic [3:0]            reg_idx;
   logic [2:0]            scr_idx;
   logic [2:0]            status_set;
   logic [2:0]            status_clr;
   logic [DATA_WIDTH-1:0] rdata_mux;

   // Decode works on the address captured in the setup cycle, not the live bus.
   assign access     = psel & penable;
   assign addr_err   = (addr_q[1:0] != 2'b00) || (addr_q > LastAddr);
   assign reg_idx    = addr_q[5:2];
   assign scr_idx    = 3'(reg_idx - 4'd3);
   assign pready     = (state_q == StResp) && access;
   assign pslverr    = pready && addr_err;
   assign wr_en      = pready && wr_q && !addr_err;
   assign status_set = {Arb_done_i, Rx_done_i, Tx_done_i};
   assign Intr       = intr_q;

   // Transfer FSM: setup capture, wait-state countdown, single response cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         StIdle: begin
            if (psel && !penable) begin
               addr_d  = paddr;
               wr_d    = pwrite;
               wdata_d = pwdata;
               cnt_d   = WaitLoad;
               // With no wait states the first access cycle is already the response.
               state_d = (WAIT_STATES == 0) ? StResp : StWait;
            end
         end
         StWait: begin
            if (!access) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q <= 3'd1) begin
               state_d = StResp;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM and captured transfer state.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
      end
   end

   // Register write decode; STATUS sources are OR-ed in after the W1C clear so a set wins.
   always_comb begin
      ctrl_d     = ctrl_q;
      int_en_d   = int_en_q;
      scratch_d  = scratch_q;
      status_clr = '0;
      if (wr_en) begin
         case (reg_idx)
            4'd0:    ctrl_d = wdata_q;
            4'd1:    int_en_d = wdata_q[2:0];
            4'd2:    status_clr = wdata_q[2:0];
            default: scratch_d[scr_idx] = wdata_q;
         endcase
      end
      status_d = (status_q & ~status_clr) | status_set;
   end

   // Register file state.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         ctrl_q   <= '0;
         int_en_q <= '0;
         status_q <= '0;
         for (int i = 0; i < NumScratch; i++) begin
            scratch_q[i] <= '0;
         end
      end else begin
         ctrl_q    <= ctrl_d;
         int_en_q  <= int_en_d;
         status_q  <= status_d;
         scratch_q <= scratch_d;
      end
   end

   // Interrupt lags the enabled status by one clock.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         intr_q <= 1'b0;
      end else begin
         intr_q <= |(status_q & int_en_q);
      end
   end

   // Read data mux; driven onto prdata only during a legal read response.
   always_comb begin
      rdata_mux = '0;
      case (reg_idx)
         4'd0:    rdata_mux = ctrl_q;
         4'd1:    rdata_mux = {{(DATA_WIDTH-3){1'b0}}, int_en_q};
         4'd2:    rdata_mux = {{(DATA_WIDTH-3){1'b0}}, status_q};
         default: rdata_mux = scratch_q[scr_idx];
      endcase
   end

   assign prdata = (pready && !wr_q && !addr_err) ? rdata_mux : '0;

endmodule
